// File: rtl/nic_link_out_ctrl_pkg.sv
// Shared NIC definitions for the link output stage: sizing constants,
// a constant clog2 helper and the scalar types built from them.
package nic_link_out_ctrl_pkg;

  // Ceiling log2 for sizing pointer and counter fields at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  localparam int N_REQUEST_SIGNAL = 6;
  localparam int N_BITS_POINTER   = clog2(N_REQUEST_SIGNAL);
  localparam int FLIT_WIDTH       = 64;
  localparam int N_CREDITS        = 4;
  localparam int N_BITS_CREDIT    = clog2(N_CREDITS + 1);

  typedef logic [N_BITS_POINTER-1:0]   chan_id_t;
  typedef logic [FLIT_WIDTH-1:0]       flit_t;
  typedef logic [N_BITS_CREDIT-1:0]    credit_t;
  typedef logic [N_REQUEST_SIGNAL-1:0] chan_vec_t;

endpackage

// File: rtl/nic_link_out_ctrl_if.sv
// Bundle of FIFO, allocator, link and credit signals seen by the link
// output stage. master = the output stage, slave = its surroundings.
interface nic_link_out_ctrl_if;
  import nic_link_out_ctrl_pkg::*;

  chan_vec_t                                flit_valid_i;
  logic [N_REQUEST_SIGNAL*FLIT_WIDTH-1:0]   flit_i;
  chan_vec_t                                flit_pop_o;
  chan_vec_t                                r_la_o;
  logic                                     g_la_i;
  chan_id_t                                 g_channel_id_i;
  flit_t                                    link_flit_o;
  logic                                     link_valid_o;
  chan_id_t                                 link_vc_o;
  logic                                     credit_i;
  chan_id_t                                 credit_vc_i;
  logic                                     grant_err_o;
  logic                                     credit_err_o;

  modport master (
    input  flit_valid_i, flit_i, g_la_i, g_channel_id_i, credit_i, credit_vc_i,
    output flit_pop_o, r_la_o, link_flit_o, link_valid_o, link_vc_o,
           grant_err_o, credit_err_o
  );

  modport slave (
    output flit_valid_i, flit_i, g_la_i, g_channel_id_i, credit_i, credit_vc_i,
    input  flit_pop_o, r_la_o, link_flit_o, link_valid_o, link_vc_o,
           grant_err_o, credit_err_o
  );

endinterface

// File: rtl/nic_credit_counter.sv
// Credit counter for one virtual channel against the router input buffer.
// Starts full, decrements on launch, increments on credit return, never wraps.
module nic_credit_counter
  import nic_link_out_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    dec,
  input  logic    inc,
  output credit_t count,
  output logic    nonzero,
  output logic    overflow
);

  localparam credit_t CREDIT_MAX = credit_t'(N_CREDITS);
  localparam credit_t CREDIT_ONE = credit_t'(1);

  // Counter update: simultaneous launch and return cancel out.
  // NOTE: state is written with <= so every counter samples the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CREDIT_MAX;
    end else if (dec && !inc && nonzero) begin
      count <= count - CREDIT_ONE;
    end else if (inc && !dec && (count != CREDIT_MAX)) begin
      count <= count + CREDIT_ONE;
    end
  end

  // Status flags; a return paired with a launch is treated as below max.
  always_comb begin
    nonzero  = (count != '0);
    overflow = inc && !dec && (count == CREDIT_MAX);
  end

endmodule

// File: rtl/nic_link_out_ctrl.sv
// Link output stage: builds allocator requests from FIFO occupancy and
// credits, pops the granted FIFO, registers the flit onto the router link
// and flags illegal grants and illegal credit returns.
module nic_link_out_ctrl
  import nic_link_out_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  nic_link_out_ctrl_if.master bus
);

  chan_vec_t credit_nz;
  chan_vec_t credit_ovf;
  chan_vec_t grant_hit;
  chan_vec_t credit_hit;
  chan_vec_t req;
  logic      grant_legal;
  logic      credit_legal;
  flit_t     sel_flit;
  chan_id_t  sel_id;
  credit_t   credit_count [N_REQUEST_SIGNAL];

  // Per-channel credit counters.
  for (genvar g = 0; g < N_REQUEST_SIGNAL; g++) begin : g_ch
    nic_credit_counter u_cnt (
      .clk      (clk),
      .rst      (rst),
      .dec      (grant_hit[g]),
      .inc      (credit_hit[g]),
      .count    (credit_count[g]),
      .nonzero  (credit_nz[g]),
      .overflow (credit_ovf[g])
    );

    // A counter outside 0..N_CREDITS means the saturation logic is broken.
    a_credit_range: assert property (@(posedge clk) disable iff (rst)
      credit_count[g] <= credit_t'(N_CREDITS));
  end

  // Requests, grant decode, credit-return decode and the launch mux.
  // NOTE: every combinational output gets a default first, so no latches form.
  always_comb begin
    req          = '0;
    grant_hit    = '0;
    credit_hit   = '0;
    sel_flit     = '0;
    sel_id       = '0;
    if (!rst) begin
      req = bus.flit_valid_i & credit_nz;
    end
    for (int i = 0; i < N_REQUEST_SIGNAL; i++) begin
      // An out-of-range id never matches any channel, so it stays illegal.
      grant_hit[i]  = bus.g_la_i && (bus.g_channel_id_i == chan_id_t'(i)) && req[i];
      credit_hit[i] = !rst && bus.credit_i && (bus.credit_vc_i == chan_id_t'(i));
      if (grant_hit[i]) begin
        sel_flit = sel_flit | bus.flit_i[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_id   = sel_id | chan_id_t'(i);
      end
    end
    grant_legal  = |grant_hit;
    credit_legal = |(credit_hit & ~credit_ovf);
  end

  assign bus.r_la_o     = req;
  assign bus.flit_pop_o = grant_hit;

  // Launch register and one-cycle error pulses; reset drops any flit in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.link_flit_o  <= '0;
      bus.link_valid_o <= 1'b0;
      bus.link_vc_o    <= '0;
      bus.grant_err_o  <= 1'b0;
      bus.credit_err_o <= 1'b0;
    end else begin
      bus.link_valid_o <= grant_legal;
      if (grant_legal) begin
        bus.link_flit_o <= sel_flit;
        bus.link_vc_o   <= sel_id;
      end
      bus.grant_err_o  <= bus.g_la_i && !grant_legal;
      bus.credit_err_o <= bus.credit_i && !credit_legal;
    end
  end

endmodule

// File: doc/nic_link_out_ctrl.md
Name: nic_link_out_ctrl

Overview:
- Output stage wrapped around the NIC link allocator, sitting between the per-channel output FIFOs and the physical link to the router.
- Drives the allocator's request vector from FIFO occupancy, masked by per-channel credit availability.
- Consumes the allocator's grant and grant id, pops the granted FIFO, and registers the flit onto the link.
- Keeps one credit counter per channel (virtual channel) against the router input buffer.

Parameters:
N_REQUEST_SIGNAL, 6, number of channels/VCs (allocator request width)
N_BITS_POINTER, clog2(N_REQUEST_SIGNAL), channel id width
FLIT_WIDTH, 64, flit data width
N_CREDITS, 4, router input buffer depth per VC (reset credit value)
N_BITS_CREDIT, clog2(N_CREDITS+1), credit counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flit_valid_i  in  N_REQUEST_SIGNAL  FIFO i non-empty
flit_i  in  N_REQUEST_SIGNAL*FLIT_WIDTH  head flits, channel i at bits [i*FLIT_WIDTH +: FLIT_WIDTH]
flit_pop_o  out  N_REQUEST_SIGNAL  one-hot pop strobe to FIFOs
r_la_o  out  N_REQUEST_SIGNAL  requests to link allocator
g_la_i  in  1  allocator grant valid
g_channel_id_i  in  N_BITS_POINTER  granted channel
link_flit_o  out  FLIT_WIDTH  flit to router
link_valid_o  out  1  flit valid on link
link_vc_o  out  N_BITS_POINTER  VC of link flit
credit_i  in  1  credit return strobe from router
credit_vc_i  in  N_BITS_POINTER  VC of returned credit
grant_err_o  out  1  one-cycle pulse: invalid grant
credit_err_o  out  1  one-cycle pulse: credit overflow/illegal vc

Behaviour:
- Reset (async, rst=1):
  - link_flit_o=0, link_valid_o=0, link_vc_o=0.
  - All credit counters = N_CREDITS.
  - grant_err_o=0, credit_err_o=0.
  - r_la_o and flit_pop_o are combinational; they are 0 while rst=1.
- Request generation (combinational): r_la_o[i] = flit_valid_i[i] & (credit[i] != 0).
- Grant acceptance (combinational in cycle T): grant is legal iff g_la_i=1, g_channel_id_i < N_REQUEST_SIGNAL, and r_la_o[g_channel_id_i]=1.
  - Legal grant: flit_pop_o = one-hot(g_channel_id_i) in T; otherwise flit_pop_o=0.
- Launch (posedge ending T, legal grant):
  - link_flit_o <= flit_i[id], link_vc_o <= id, link_valid_o <= 1.
  - credit[id] decremented. Latency grant->link valid = 1 cycle.
- No legal grant in T: link_valid_o <= 0; link_flit_o and link_vc_o hold their last values.
- Illegal grant (g_la_i=1 but not legal): no pop, no credit change; grant_err_o <= 1 for one cycle.
- Credit return (credit_i=1):
  - Legal return (credit_vc_i < N_REQUEST_SIGNAL and credit[vc] < N_CREDITS): credit[vc]+1 at next posedge.
  - Return with counter already at N_CREDITS or out-of-range vc: ignored; credit_err_o pulses one cycle.
- Simultaneous launch and credit return on the same vc: counter unchanged. Its evaluation counts as "below max" and raises no error.
- Different vcs: both updates apply in the same cycle.
- Back-to-back grants to one channel:
  - Allowed every cycle while FIFO non-empty and credit > 0.
  - When credit reaches 0 the request drops combinationally in the same cycle the counter updates.
- Counters never wrap: decrement only under a legal grant (credit > 0); increment saturates per the rule above.
- rst asserted mid-stream:
  - In-flight link flit is dropped (link_valid_o=0 immediately).
  - Credits restored to N_CREDITS; no pops are issued.

Decomposition:
- Shared NIC defines/utils: clog2 function; FLIT_WIDTH and credit-depth constants.
- Sub-module nic_credit_counter: one instance per channel. Ports: clk, rst, dec, inc, count, nonzero, overflow. Generated N_REQUEST_SIGNAL times.
- The top handles the mux, the launch register and error pulses.

Test Plan:
1. Reset release with all FIFOs empty -> r_la_o=0, link_valid_o=0, all credits read 4, no pops.
2. flit_valid_i=6'b000100, flit_i[2]=64'hA5; grant id 2 in cycle T -> flit_pop_o=6'b000100 in T; at T+1 link_valid_o=1, link_flit_o=64'hA5, link_vc_o=2.
3. Channel 1 always valid, granted 4 consecutive cycles, no credit return -> 4 flits sent; r_la_o[1]=0 afterwards. A 5th grant to id 1 -> grant_err_o pulse, no pop.
4. Credit[3]=0, then credit_i with credit_vc_i=3 -> next cycle r_la_o[3]=1 (FIFO valid). Grant plus credit return on vc 3 in the same cycle -> credit stays 1, no credit_err_o.
5. credit_i with vc 0 while credit[0]=4 -> credit_err_o one-cycle pulse, counter stays 4. credit_vc_i=7 -> credit_err_o pulse.
6. rst asserted while link_valid_o=1 and credit[5]=1 -> link_valid_o=0 immediately; after release credit[5]=4.
